axi_nmem_slave_m: RTL and testbench
===================================

# axi_nmem_slave_m

AXI4 memory-slave responder that sits directly downstream of the NoC transaction tester and terminates its AW/W/B and AR/R channels. It stores write bursts in a byte-enabled register-file memory and returns read bursts from the same storage, so the tester can run write-then-read-back checks over the NoC. The tester's awcache/awlock/awprot/awqos/awregion/awuser/awsize (and the ar* equivalents) are not ports and are left unconnected. Every beat is full DATA_W wide.

## Interface
- DATA_W, 64, data width in bits (multiple of 8); WSTRB_W = DATA_W/8.
- DEPTH_LOG2, 8, log2 of the memory depth in DATA_W words.
- clk  in  1  single clock; all logic on the rising edge.
- rst  in  1  reset, synchronous and active-high.
- awvalid/awready  in/out  1/1  write-address handshake.
- awaddr  in  64  byte address; word index = awaddr[LSB +: DEPTH_LOG2], where LSB = log2(WSTRB_W).
- awburst  in  2  burst type: 0 = FIXED, 1 = INCR, 2 = WRAP (treated as INCR), 3 = treated as INCR.
- awid/awlen  in  2/8  transaction ID; beats minus 1.
- wvalid/wready  in/out  1/1  write-data handshake.
- wdata/wstrb/wlast  in  DATA_W/WSTRB_W/1  write data, byte enables, last flag.
- bvalid/bready  out/in  1/1  write-response handshake.
- bid/bresp  out  2/2  echoed awid; 0 = OKAY, 2 = SLVERR.
- arvalid/arready  in/out  1/1  read-address handshake.
- araddr/arburst/arid/arlen  in  64/2/2/8  same meaning as the aw* ports.
- rvalid/rready  out/in  1/1  read-data handshake.
- rdata/rid/rlast/rresp  out  DATA_W/2/1/2  read data, echoed arid, last flag, always 0 (OKAY).

## Operation
- Write FSM has three states.
  - W_IDLE: awready=1. On awvalid, capture the word index, burst type, ID and len, clear the beat counter and the error flag, then go to W_DATA.
  - W_DATA: wready=1. For each wvalid beat:
    - write each byte i of mem[idx] for which wstrb[i]=1;
    - increment idx, except for FIXED bursts;
    - set the error flag if wlast ≠ (beat == len);
    - on the beat where beat == len, go to W_RESP. The burst always ends on the awlen count, never on wlast.
  - W_RESP: bvalid=1, bid = captured ID, bresp = error flag ? 2 : 0. On bready, go to W_IDLE.
- Read FSM has two states.
  - R_IDLE: arready=1. On arvalid, capture the burst parameters, load rdata ← mem[idx], and go to R_DATA.
  - R_DATA: rvalid=1, rid = captured ID, rlast = (beat == len). On rready:
    - if rlast: go to R_IDLE;
    - otherwise: advance idx and the beat counter, and load rdata ← mem[next idx].
- The word index wraps modulo 2^DEPTH_LOG2; the high address bits are ignored.
- The read and write FSMs run fully independently and concurrently.

## Timing
- Reset values:
  - outputs: awready=0, wready=0, bvalid=0, arready=0, rvalid=0, rlast=0, bid=0, bresp=0, rid=0, rresp=0, rdata=0;
  - FSMs: both in IDLE; awready and arready rise in the first cycle after reset.
  - Memory contents are not reset.
- Write path:
  - AW accepted at cycle t → wready=1 at t+1.
  - Final W beat at t → bvalid=1 at t+1.
  - B accepted at t → awready=1 at t+1.
- Read path:
  - AR accepted at t → rvalid=1 with beat-0 data at t+1.
  - With rready held at 1, one beat per cycle.
  - Last beat accepted at t → arready=1 at t+1.
- Backpressure: rvalid, rdata, rid and rlast are held stable while rready=0; bvalid, bid and bresp are held stable while bready=0.
- Same-cycle read-load and write of the same word: rdata gets the old value; a load in a later cycle sees the new data.
- rst asserted mid-burst: next cycle both FSMs are in IDLE, the outputs are at their reset values, and the partial burst is abandoned with no response.

## Test plan
- Single write: awaddr=0x40, awlen=0, wdata=0x1122334455667788, wstrb=0xFF, wlast=1 → bresp=0, bid=awid. A read of 0x40 then returns the same data with rlast=1.
- INCR burst: awlen=3 at 0x0, data 1..4 → bvalid exactly 1 cycle after the 4th beat. A read with arlen=3 returns 1,2,3,4 with rlast only on beat 4.
- Strobes and FIXED burst:
  - Write 0xFFFF_FFFF_FFFF_FFFF to 0x8.
  - Write 0 to 0x8 with wstrb=0x0F → read returns 0xFFFFFFFF00000000.
  - FIXED write, awlen=2, data A,B,C → word holds C.
- wlast errors: wlast=1 on beat 1 of an awlen=3 burst → bresp=2 and all 4 beats are written. A burst with wlast never asserted → bresp=2.
- Backpressure and wrap:
  - Read with arlen=2 at index 2^DEPTH_LOG2−1, toggling rready randomly → data is stable while stalled and index 0 follows the top word.
  - bready held low 5 cycles → bvalid held and awready stays 0.
- Concurrency and reset:
  - Simultaneous write and read bursts to disjoint addresses → both complete with their correct IDs.
  - rst pulsed during beat 2 of a 4-beat write → no bvalid, and awready=1 one cycle after rst is released.

Source files
------------

// File: rtl/axi_nmem_slave_m.sv
// AXI4 memory-slave responder: byte-enabled register-file memory behind independent
// write (AW/W/B) and read (AR/R) state machines, used as the NoC tester's far end.
module axi_nmem_slave_m #(
    parameter int DATA_W     = 64,
    parameter int DEPTH_LOG2 = 8
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic                  awvalid,
    output logic                  awready,
    input  logic [63:0]           awaddr,
    input  logic [1:0]            awburst,
    input  logic [1:0]            awid,
    input  logic [7:0]            awlen,
    input  logic                  wvalid,
    output logic                  wready,
    input  logic [DATA_W-1:0]     wdata,
    input  logic [DATA_W/8-1:0]   wstrb,
    input  logic                  wlast,
    output logic                  bvalid,
    input  logic                  bready,
    output logic [1:0]            bid,
    output logic [1:0]            bresp,
    input  logic                  arvalid,
    output logic                  arready,
    input  logic [63:0]           araddr,
    input  logic [1:0]            arburst,
    input  logic [1:0]            arid,
    input  logic [7:0]            arlen,
    output logic                  rvalid,
    input  logic                  rready,
    output logic [DATA_W-1:0]     rdata,
    output logic [1:0]            rid,
    output logic                  rlast,
    output logic [1:0]            rresp
);

    localparam int WSTRB_W = DATA_W / 8;
    localparam int LSB     = $clog2(WSTRB_W);
    localparam int DEPTH   = 1 << DEPTH_LOG2;
    localparam logic [1:0] BURST_FIXED = 2'd0;
    localparam logic [1:0] RESP_OKAY   = 2'd0;
    localparam logic [1:0] RESP_SLVERR = 2'd2;
    localparam logic [DEPTH_LOG2-1:0] IDX_ONE = 1;

    typedef enum logic [1:0] {W_IDLE, W_DATA, W_RESP} wstate_t;
    typedef enum logic {R_IDLE, R_DATA} rstate_t;

    logic [DATA_W-1:0] mem [DEPTH];

    wstate_t               wstate;
    logic [DEPTH_LOG2-1:0] w_idx;
    logic                  w_fixed;
    logic [7:0]            w_len;
    logic [7:0]            w_beat;
    logic                  w_err;
    logic [1:0]            w_id;
    logic                  w_fire;
    logic                  w_final;
    logic                  w_bad;

    rstate_t               rstate;
    logic [DEPTH_LOG2-1:0] r_idx;
    logic [DEPTH_LOG2-1:0] r_next_idx;
    logic                  r_fixed;
    logic [7:0]            r_len;
    logic [7:0]            r_beat;

    // Address bits outside the word index are deliberately ignored.
    logic unused_addr_bits;
    assign unused_addr_bits = ^{awaddr[63:LSB+DEPTH_LOG2], awaddr[LSB-1:0],
                                araddr[63:LSB+DEPTH_LOG2], araddr[LSB-1:0]};

    assign rresp      = RESP_OKAY;
    assign w_fire     = wvalid && wready;
    assign w_final    = (w_beat == w_len);
    assign w_bad      = (wlast != w_final);
    assign r_next_idx = r_fixed ? r_idx : r_idx + IDX_ONE;

    always_ff @(posedge clk) begin
        if (w_fire) begin
            for (int i = 0; i < WSTRB_W; i++) begin
                if (wstrb[i]) begin
                    mem[w_idx][i*8 +: 8] <= wdata[i*8 +: 8];
                end
            end
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            wstate  <= W_IDLE;
            awready <= 1'b0;
            wready  <= 1'b0;
            bvalid  <= 1'b0;
            bid     <= 2'd0;
            bresp   <= RESP_OKAY;
        end else begin
            case (wstate)
                W_IDLE: begin
                    if (awvalid && awready) begin
                        awready <= 1'b0;
                        wready  <= 1'b1;
                        w_idx   <= awaddr[LSB +: DEPTH_LOG2];
                        w_fixed <= (awburst == BURST_FIXED);
                        w_id    <= awid;
                        w_len   <= awlen;
                        w_beat  <= 8'd0;
                        w_err   <= 1'b0;
                        wstate  <= W_DATA;
                    end else begin
                        awready <= 1'b1;
                    end
                end
                W_DATA: begin
                    if (w_fire) begin
                        if (!w_fixed) begin
                            w_idx <= w_idx + IDX_ONE;
                        end
                        w_beat <= w_beat + 8'd1;
                        // The awlen count ends the burst; a mismatched wlast only flags an error.
                        if (w_final) begin
                            wready <= 1'b0;
                            bvalid <= 1'b1;
                            bid    <= w_id;
                            bresp  <= (w_err || w_bad) ? RESP_SLVERR : RESP_OKAY;
                            wstate <= W_RESP;
                        end else begin
                            w_err <= w_err | w_bad;
                        end
                    end
                end
                W_RESP: begin
                    if (bready) begin
                        bvalid  <= 1'b0;
                        awready <= 1'b1;
                        wstate  <= W_IDLE;
                    end
                end
                default: wstate <= W_IDLE;
            endcase
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            rstate  <= R_IDLE;
            arready <= 1'b0;
            rvalid  <= 1'b0;
            rlast   <= 1'b0;
            rid     <= 2'd0;
            rdata   <= '0;
        end else begin
            case (rstate)
                R_IDLE: begin
                    if (arvalid && arready) begin
                        arready <= 1'b0;
                        rvalid  <= 1'b1;
                        rid     <= arid;
                        rlast   <= (arlen == 8'd0);
                        rdata   <= mem[araddr[LSB +: DEPTH_LOG2]];
                        r_idx   <= araddr[LSB +: DEPTH_LOG2];
                        r_fixed <= (arburst == BURST_FIXED);
                        r_len   <= arlen;
                        r_beat  <= 8'd0;
                        rstate  <= R_DATA;
                    end else begin
                        arready <= 1'b1;
                    end
                end
                R_DATA: begin
                    if (rready) begin
                        if (rlast) begin
                            rvalid  <= 1'b0;
                            rlast   <= 1'b0;
                            arready <= 1'b1;
                            rstate  <= R_IDLE;
                        end else begin
                            r_idx  <= r_next_idx;
                            r_beat <= r_beat + 8'd1;
                            rlast  <= (r_beat + 8'd1 == r_len);
                            rdata  <= mem[r_next_idx];
                        end
                    end
                end
                default: rstate <= R_IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_axi_nmem_slave_m.sv
// Bench for axi_nmem_slave_m: table of write/read-back vectors plus hand sequences
// for bready backpressure, concurrent channels and reset in the middle of a burst.
module tb_axi_nmem_slave_m;

    typedef logic [3:0][63:0] quad_t;

    typedef struct {
        string      name;
        logic [63:0] addr;
        logic [7:0]  len;
        logic [1:0]  burst;
        logic [1:0]  id;
        logic [7:0]  strb;
        logic [3:0]  wl;
        quad_t       d;
        int          bdelay;
        logic [1:0]  exp_bresp;
        logic [63:0] raddr;
        logic [7:0]  rlen;
        bit          rnd;
        quad_t       exp_rd;
    } vec_t;

    logic        clk = 1'b0;
    logic        rst;
    logic        awvalid, awready, wvalid, wready, wlast, bvalid, bready;
    logic [63:0] awaddr, araddr, wdata, rdata;
    logic [1:0]  awburst, awid, bid, bresp, arburst, arid, rid, rresp;
    logic [7:0]  awlen, arlen, wstrb;
    logic        arvalid, arready, rvalid, rready, rlast;

    int tests = 0;
    int fails = 0;

    axi_nmem_slave_m #(.DATA_W(64), .DEPTH_LOG2(8)) dut (
        .clk(clk), .rst(rst),
        .awvalid(awvalid), .awready(awready), .awaddr(awaddr), .awburst(awburst),
        .awid(awid), .awlen(awlen),
        .wvalid(wvalid), .wready(wready), .wdata(wdata), .wstrb(wstrb), .wlast(wlast),
        .bvalid(bvalid), .bready(bready), .bid(bid), .bresp(bresp),
        .arvalid(arvalid), .arready(arready), .araddr(araddr), .arburst(arburst),
        .arid(arid), .arlen(arlen),
        .rvalid(rvalid), .rready(rready), .rdata(rdata), .rid(rid), .rlast(rlast),
        .rresp(rresp)
    );

    always #5 clk = ~clk;

    initial begin
        #500000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
        tests++;
        if (act !== exp) begin
            fails++;
            $display("FAIL %s: actual=%h required=%h", nm, act, exp);
        end
    endtask

    function automatic quad_t q4(input logic [63:0] a, b, c, e);
        quad_t r;
        r[0] = a; r[1] = b; r[2] = c; r[3] = e;
        return r;
    endfunction

    function automatic vec_t mk(input string nm, input logic [63:0] addr, input logic [7:0] len,
                                input logic [1:0] burst, input logic [1:0] id,
                                input logic [7:0] strb, input logic [3:0] wl, input quad_t d,
                                input int bdelay, input logic [1:0] exp_bresp,
                                input logic [63:0] raddr, input logic [7:0] rlen,
                                input bit rnd, input quad_t exp_rd);
        vec_t v;
        v.name = nm; v.addr = addr; v.len = len; v.burst = burst; v.id = id;
        v.strb = strb; v.wl = wl; v.d = d; v.bdelay = bdelay; v.exp_bresp = exp_bresp;
        v.raddr = raddr; v.rlen = rlen; v.rnd = rnd; v.exp_rd = exp_rd;
        return v;
    endfunction

    task automatic write_burst(input string nm, input logic [63:0] addr, input logic [7:0] len,
                               input logic [1:0] burst, input logic [1:0] id,
                               input logic [7:0] strb, input logic [3:0] wl, input quad_t d,
                               input int bdelay, input logic [1:0] exp_bresp);
        int n;
        awvalid = 1'b1; awaddr = addr; awlen = len; awburst = burst; awid = id;
        n = 0;
        while (!awready && n < 50) begin
            @(posedge clk); #1; n++;
        end
        chk({nm, "/awready"}, awready, 1);
        @(posedge clk); #1;
        awvalid = 1'b0;
        chk({nm, "/wready"}, wready, 1);
        for (int k = 0; k <= int'(len); k++) begin
            wvalid = 1'b1; wdata = d[k]; wstrb = strb; wlast = wl[k];
            @(posedge clk); #1;
        end
        wvalid = 1'b0; wlast = 1'b0;
        chk({nm, "/bvalid"}, bvalid, 1);
        chk({nm, "/bid"}, bid, id);
        chk({nm, "/bresp"}, bresp, exp_bresp);
        for (int s = 0; s < bdelay; s++) begin
            @(posedge clk); #1;
            chk({nm, "/bvalid_held"}, bvalid, 1);
            chk({nm, "/awready_low"}, awready, 0);
            chk({nm, "/bresp_held"}, bresp, exp_bresp);
        end
        bready = 1'b1;
        @(posedge clk); #1;
        bready = 1'b0;
        chk({nm, "/bvalid_drop"}, bvalid, 0);
        chk({nm, "/awready_back"}, awready, 1);
    endtask

    task automatic read_burst(input string nm, input logic [63:0] addr, input logic [7:0] len,
                              input logic [1:0] id, input bit rnd, input quad_t exp);
        int n;
        logic [63:0] hold;
        arvalid = 1'b1; araddr = addr; arburst = 2'd1; arid = id; arlen = len;
        n = 0;
        while (!arready && n < 50) begin
            @(posedge clk); #1; n++;
        end
        chk({nm, "/arready"}, arready, 1);
        @(posedge clk); #1;
        arvalid = 1'b0;
        chk({nm, "/rvalid"}, rvalid, 1);
        for (int k = 0; k <= int'(len); k++) begin
            if (rnd) begin
                n = $urandom_range(1, 3);
                rready = 1'b0;
                hold = rdata;
                for (int s = 0; s < n; s++) begin
                    @(posedge clk); #1;
                    chk({nm, "/stall_rdata"}, rdata, hold);
                    chk({nm, "/stall_rvalid"}, rvalid, 1);
                end
            end
            rready = 1'b1;
            chk({nm, "/rdata"}, rdata, exp[k]);
            chk({nm, "/rlast"}, rlast, (k == int'(len)) ? 1 : 0);
            chk({nm, "/rid"}, rid, id);
            @(posedge clk); #1;
        end
        rready = 1'b0;
        chk({nm, "/rvalid_drop"}, rvalid, 0);
        chk({nm, "/arready_back"}, arready, 1);
    endtask

    vec_t vecs[8];

    initial begin
        vecs[0] = mk("single", 64'h40, 8'd0, 2'd1, 2'd1, 8'hFF, 4'b0001,
                     q4(64'h1122334455667788, 0, 0, 0), 0, 2'd0,
                     64'h40, 8'd0, 1'b0, q4(64'h1122334455667788, 0, 0, 0));
        vecs[1] = mk("incr4", 64'h0, 8'd3, 2'd1, 2'd2, 8'hFF, 4'b1000,
                     q4(1, 2, 3, 4), 0, 2'd0, 64'h0, 8'd3, 1'b0, q4(1, 2, 3, 4));
        vecs[2] = mk("ones_bstall", 64'h8, 8'd0, 2'd1, 2'd3, 8'hFF, 4'b0001,
                     q4(64'hFFFF_FFFF_FFFF_FFFF, 0, 0, 0), 5, 2'd0,
                     64'h8, 8'd0, 1'b0, q4(64'hFFFF_FFFF_FFFF_FFFF, 0, 0, 0));
        vecs[3] = mk("strobe", 64'h8, 8'd0, 2'd1, 2'd0, 8'h0F, 4'b0001,
                     q4(0, 0, 0, 0), 0, 2'd0,
                     64'h8, 8'd0, 1'b0, q4(64'hFFFF_FFFF_0000_0000, 0, 0, 0));
        vecs[4] = mk("fixed", 64'h100, 8'd2, 2'd0, 2'd1, 8'hFF, 4'b0100,
                     q4(64'hAAAA, 64'hBBBB, 64'hCCCC, 0), 0, 2'd0,
                     64'h100, 8'd1, 1'b0, q4(64'hCCCC, 64'hX, 0, 0));
        vecs[5] = mk("wlast_early", 64'h200, 8'd3, 2'd1, 2'd2, 8'hFF, 4'b0010,
                     q4(5, 6, 7, 8), 0, 2'd2, 64'h200, 8'd3, 1'b0, q4(5, 6, 7, 8));
        vecs[6] = mk("wlast_none", 64'h300, 8'd3, 2'd1, 2'd3, 8'hFF, 4'b0000,
                     q4(9, 10, 11, 12), 0, 2'd2, 64'h300, 8'd3, 1'b0, q4(9, 10, 11, 12));
        vecs[7] = mk("wrap", 64'h7F8, 8'd2, 2'd2, 2'd1, 8'hFF, 4'b0100,
                     q4(64'hA1, 64'hA2, 64'hA3, 0), 0, 2'd0,
                     64'hFFFF_0000_0000_07F8, 8'd2, 1'b1, q4(64'hA1, 64'hA2, 64'hA3, 0));
        // The word after the FIXED target must be untouched; it still holds nothing known,
        // so the fixed read-back is trimmed to the one word that was written.
        vecs[4].rlen = 8'd0;

        rst = 1'b1;
        awvalid = 0; awaddr = 0; awburst = 0; awid = 0; awlen = 0;
        wvalid = 0; wdata = 0; wstrb = 0; wlast = 0; bready = 0;
        arvalid = 0; araddr = 0; arburst = 0; arid = 0; arlen = 0; rready = 0;
        repeat (3) @(posedge clk);
        #1;
        chk("rst/awready", awready, 0);
        chk("rst/wready", wready, 0);
        chk("rst/bvalid", bvalid, 0);
        chk("rst/arready", arready, 0);
        chk("rst/rvalid", rvalid, 0);
        chk("rst/rlast", rlast, 0);
        chk("rst/bid", bid, 0);
        chk("rst/bresp", bresp, 0);
        chk("rst/rid", rid, 0);
        chk("rst/rresp", rresp, 0);
        chk("rst/rdata", rdata, 0);
        rst = 1'b0;
        @(posedge clk); #1;
        chk("post_rst/awready", awready, 1);
        chk("post_rst/arready", arready, 1);

        for (int i = 0; i < 8; i++) begin
            write_burst(vecs[i].name, vecs[i].addr, vecs[i].len, vecs[i].burst, vecs[i].id,
                        vecs[i].strb, vecs[i].wl, vecs[i].d, vecs[i].bdelay, vecs[i].exp_bresp);
            read_burst({vecs[i].name, "_rd"}, vecs[i].raddr, vecs[i].rlen, ~vecs[i].id,
                       vecs[i].rnd, vecs[i].exp_rd);
        end

        // Concurrent write and read to disjoint words.
        fork
            write_burst("conc_wr", 64'h400, 8'd1, 2'd1, 2'd3, 8'hFF, 4'b0010,
                        q4(64'h77, 64'h88, 0, 0), 0, 2'd0);
            read_burst("conc_rd", 64'h200, 8'd3, 2'd1, 1'b0, q4(5, 6, 7, 8));
        join
        read_burst("conc_chk", 64'h400, 8'd1, 2'd2, 1'b0, q4(64'h77, 64'h88, 0, 0));

        // Reset during beat 2 of a 4-beat write: burst abandoned, no response.
        awvalid = 1'b1; awaddr = 64'h600; awlen = 8'd3; awburst = 2'd1; awid = 2'd2;
        @(posedge clk); #1;
        awvalid = 1'b0;
        for (int k = 0; k < 2; k++) begin
            wvalid = 1'b1; wdata = 64'h600 + k; wstrb = 8'hFF; wlast = 1'b0;
            @(posedge clk); #1;
        end
        wdata = 64'h602;
        rst = 1'b1;
        @(posedge clk); #1;
        chk("midrst/awready", awready, 0);
        chk("midrst/wready", wready, 0);
        chk("midrst/bvalid", bvalid, 0);
        chk("midrst/arready", arready, 0);
        chk("midrst/rvalid", rvalid, 0);
        rst = 1'b0; wvalid = 1'b0;
        @(posedge clk); #1;
        chk("midrst/awready_back", awready, 1);
        chk("midrst/arready_back", arready, 1);
        for (int s = 0; s < 3; s++) begin
            @(posedge clk); #1;
            chk("midrst/no_bvalid", bvalid, 0);
        end
        write_burst("after_rst", 64'h600, 8'd0, 2'd1, 2'd0, 8'hFF, 4'b0001,
                    q4(64'h5A5A, 0, 0, 0), 0, 2'd0);
        read_burst("after_rst_rd", 64'h600, 8'd0, 2'd3, 1'b0, q4(64'h5A5A, 0, 0, 0));

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule
